scrambler_par: RTL and testbench
================================

Name: scrambler_par

Overview:
- Parametrised successor to the serial 802.11a length-127 frame-synchronous scrambler; one instance serves both TX scrambling and RX descrambling.
- Processes W bits per clock, with the LFSR step unrolled W times per beat.
- Valid/ready streaming handshake with a registered output stage; frames delimited by first/last sideband flags.
- RX mode recovers the seed from the SERVICE field's leading zero bits, so no seed input is needed on the receive path.

Parameters:
- W, 1, bits per beat (1..8); iData[0] is earliest in time.
- LFSR_LEN, 7, LFSR length in bits.
- TAP_A, 7, first feedback tap (1-based LFSR index).
- TAP_B, 4, second feedback tap; feedback/keystream bit = LFSR[TAP_A]^LFSR[TAP_B].

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iMode  in  1  0 = TX (seed from iState), 1 = RX (seed recovery); sampled on the first beat.
- iState  in  LFSR_LEN  TX seed, bit LFSR_LEN..1 = LFSR[LEN..1]; sampled on the first beat.
- iData  in  W  input bits.
- iFirst  in  1  beat is the first of a frame.
- iLast  in  1  beat is the last of a frame.
- iValid  in  1  input beat valid.
- oReady  out  1  input beat accepted when iValid&&oReady.
- oData  out  W  scrambled/descrambled bits.
- oValid  out  1  output beat valid.
- iReady  in  1  downstream ready.
- oLocked  out  1  RX seed recovered (TX: high from the first beat).
- oSeed  out  LFSR_LEN  recovered RX seed; TX: loaded seed.

Behaviour:
- Reset (async assert, sync deassert by user): all of these cleared to 0: LFSR, oData, oValid, oLocked, oSeed, bit counter. State = IDLE.
- oReady = !oValid || iReady, combinational.
  - Output register loads on accept.
  - oValid/oData hold while oValid && !iReady.
  - The LFSR advances only on accept.
- Latency: 1 cycle from accept to oValid.
- States:
  - IDLE:
    - Accepted beat without iFirst is discarded, with no output and no LFSR change.
    - Accepted beat with iFirst, iMode=0: LFSR := iState, this beat is processed from the seed, oLocked=1, oSeed=iState, state goes to RUN.
    - Accepted beat with iFirst, iMode=1: LFSR := 0, count := 0, oLocked=0, state goes to RECOVER and this beat is processed in recover rules.
  - RECOVER (per bit, in time order within a beat): while count < LEN:
    - The received bit shifts directly into LFSR[1], with LFSR[k] <= LFSR[k-1].
    - The output bit is forced to 0.
    - count increments.
    - Once count = LEN, the remaining bits of the same beat use RUN rules.
    - At end of the beat where count reaches LEN: oLocked=1, oSeed := LFSR, state goes to RUN.
  - RUN (per bit): ks = LFSR[TAP_A]^LFSR[TAP_B]; out = in ^ ks; shift with LFSR[1] <= ks.
- iLast on an accepted beat returns the state to IDLE after that beat.
  - oLocked and oSeed hold until the next iFirst.
  - iFirst and iLast on the same beat form a single-beat frame.
- Simultaneous events:
  - iFirst accepted in RECOVER/RUN aborts the current frame and restarts per the IDLE rules.
  - iFirst has priority over iLast of the old frame.
  - iLast in RECOVER before the count completes: return to IDLE, oLocked stays 0.
- All-zero TX seed is loaded as-is; keystream is all-zero and data passes through unchanged. No error flag is raised.
- Reset mid-frame:
  - Outputs clear immediately.
  - The in-flight output beat is lost.
  - Subsequent beats are dropped until iFirst.
- Count is a 3-bit saturating counter (clog2(LEN+1)); no wrap.

Decomposition:
- Package scrambler_pkg:
  - state enum {IDLE, RECOVER, RUN}.
  - LFSR_LEN_DEF=7, TAP_A_DEF=7, TAP_B_DEF=4.
  - MODE_TX=0, MODE_RX=1.
- Sub-module scrambler_step: combinational W-bit unroll. Inputs are LFSR state, data, recovering flag, and count. Outputs are next LFSR, next count, and out bits.
- scrambler_par owns the FSM, handshake, and output registers.

Test Plan:
1. W=1, TX, iState=7'b1111111, 16 zero bits -> oData serial 0000111011110010; oLocked=1, oSeed=7'b1111111.
2. W=8, TX, seed 7'b1111111, zero data -> oData beats 8'h70, 8'h4F, then the 127-bit 802.11a sequence continues, with period 127 bits over a long frame.
3. W=1, RX, input = the output of test 1 (16 bits) -> first 7 oData=0, then all 0; oLocked rises after bit 7; oSeed=7'b0000111.
4. W=8, TX, iReady low for 3 cycles mid-frame -> oValid/oData stable, oReady=0, no LFSR advance; the final stream is identical to test 2.
5. iRst_n pulsed low mid-frame -> oValid/oLocked/oSeed = 0 immediately; next beats without iFirst are consumed with no output; next iFirst restarts correctly.
6. iFirst with seed 7'b1011101 arriving mid-frame (prior frame unfinished), plus a single-beat iFirst&iLast frame -> output matches a golden model started fresh on that beat; FSM returns to IDLE after the single beat.

Source files
------------

// File: rtl/scrambler_pkg.sv
// Shared types and defaults for the parallel 802.11a-style scrambler/descrambler.
// Pulled in by scrambler_par and scrambler_step.
package scrambler_pkg;

  localparam int unsigned LFSR_LEN_DEF = 7;
  localparam int unsigned TAP_A_DEF    = 7;
  localparam int unsigned TAP_B_DEF    = 4;

  localparam logic MODE_TX = 1'b0;
  localparam logic MODE_RX = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOVER = 2'd1,
    RUN     = 2'd2
  } state_e;

endpackage

// File: rtl/scrambler_step.sv
// Combinational W-bit unroll of the LFSR step.
// Bits are handled in time order, with iData bit 0 first.
module scrambler_step
  import scrambler_pkg::*;
#(
  parameter int unsigned W        = 1,
  parameter int unsigned LFSR_LEN = LFSR_LEN_DEF,
  parameter int unsigned TAP_A    = TAP_A_DEF,
  parameter int unsigned TAP_B    = TAP_B_DEF,
  parameter int unsigned CW       = 3
) (
  input  logic [LFSR_LEN-1:0] lfsr_i,
  input  logic [W-1:0]        data_i,
  input  logic                recover_i,
  input  logic [CW-1:0]       cnt_i,
  output logic [LFSR_LEN-1:0] lfsr_o,
  output logic [CW-1:0]       cnt_o,
  output logic [W-1:0]        data_o,
  output logic                lock_o,
  output logic [LFSR_LEN-1:0] seed_o
);

  localparam logic [CW-1:0] CNT_FULL = CW'(LFSR_LEN);

  logic [LFSR_LEN-1:0] lfsr_v;
  logic [CW-1:0]       cnt_v;
  logic [W-1:0]        din_v;
  logic                ks;
  logic                bit_in;

  // Recover bits load the received bit as-is until the counter fills; the rest run the keystream.
  always_comb begin
    lfsr_v = lfsr_i;
    cnt_v  = cnt_i;
    data_o = '0;
    lock_o = 1'b0;
    seed_o = '0;
    ks     = 1'b0;
    bit_in = 1'b0;
    din_v  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      din_v  = data_i >> i;
      bit_in = din_v[0];
      if (recover_i && (cnt_v < CNT_FULL)) begin
        lfsr_v = {lfsr_v[LFSR_LEN-2:0], bit_in};
        cnt_v  = cnt_v + CW'(1);
        if (cnt_v == CNT_FULL) begin
          lock_o = 1'b1;
          seed_o = lfsr_v;
        end
      end else begin
        ks     = lfsr_v[TAP_A-1] ^ lfsr_v[TAP_B-1];
        data_o = data_o | (W'(bit_in ^ ks) << i);
        lfsr_v = {lfsr_v[LFSR_LEN-2:0], ks};
      end
    end
    lfsr_o = lfsr_v;
    cnt_o  = cnt_v;
  end

endmodule

// File: rtl/scrambler_par.sv
// Frame-synchronous W-bit-per-beat scrambler (TX) / self-synchronising seed-recovery descrambler (RX).
// Contains the frame FSM, the valid/ready handshake and the registered output stage.
module scrambler_par
  import scrambler_pkg::*;
#(
  parameter int unsigned W        = 1,
  parameter int unsigned LFSR_LEN = LFSR_LEN_DEF,
  parameter int unsigned TAP_A    = TAP_A_DEF,
  parameter int unsigned TAP_B    = TAP_B_DEF
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iMode,
  input  logic [LFSR_LEN-1:0] iState,
  input  logic [W-1:0]        iData,
  input  logic                iFirst,
  input  logic                iLast,
  input  logic                iValid,
  output logic                oReady,
  output logic [W-1:0]        oData,
  output logic                oValid,
  input  logic                iReady,
  output logic                oLocked,
  output logic [LFSR_LEN-1:0] oSeed
);

  localparam int unsigned CW = $clog2(LFSR_LEN + 1);

  state_e              state_q, state_d;
  logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        data_q, data_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic [LFSR_LEN-1:0] seed_q, seed_d;

  logic                accept;
  logic                is_tx;
  logic [LFSR_LEN-1:0] step_lfsr;
  logic [CW-1:0]       step_cnt;
  logic                step_rec;
  logic [LFSR_LEN-1:0] step_lfsr_nx;
  logic [CW-1:0]       step_cnt_nx;
  logic [W-1:0]        step_data;
  logic                step_lock;
  logic [LFSR_LEN-1:0] step_seed;

  assign oReady  = !valid_q || iReady;
  assign accept  = iValid && oReady;
  assign is_tx   = (iMode == MODE_TX);
  assign oData   = data_q;
  assign oValid  = valid_q;
  assign oLocked = locked_q;
  assign oSeed   = seed_q;

  // A first beat restarts from a fresh seed (TX) or an empty recovery register (RX), whatever state we are in.
  always_comb begin
    step_lfsr = lfsr_q;
    step_cnt  = cnt_q;
    step_rec  = (state_q == RECOVER);
    if (iFirst) begin
      step_cnt = '0;
      if (is_tx) begin
        step_lfsr = iState;
        step_rec  = 1'b0;
      end else begin
        step_lfsr = '0;
        step_rec  = (iMode == MODE_RX);
      end
    end
  end

  scrambler_step #(
    .W        (W),
    .LFSR_LEN (LFSR_LEN),
    .TAP_A    (TAP_A),
    .TAP_B    (TAP_B),
    .CW       (CW)
  ) u_step (
    .lfsr_i    (step_lfsr),
    .data_i    (iData),
    .recover_i (step_rec),
    .cnt_i     (step_cnt),
    .lfsr_o    (step_lfsr_nx),
    .cnt_o     (step_cnt_nx),
    .data_o    (step_data),
    .lock_o    (step_lock),
    .seed_o    (step_seed)
  );

  // Next-state and output-register logic; an accepted beat in IDLE without iFirst is silently dropped.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q && !iReady;
    locked_d = locked_q;
    seed_d   = seed_q;
    if (accept && (iFirst || (state_q != IDLE))) begin
      lfsr_d  = step_lfsr_nx;
      cnt_d   = step_cnt_nx;
      data_d  = step_data;
      valid_d = 1'b1;
      state_d = step_rec ? RECOVER : RUN;
      if (iFirst) begin
        locked_d = is_tx;
        seed_d   = is_tx ? iState : '0;
      end
      if (step_lock) begin
        locked_d = 1'b1;
        seed_d   = step_seed;
        state_d  = RUN;
      end
      if (iLast) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      seed_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      seed_q   <= seed_d;
    end
  end

endmodule

// File: tb/tb_scrambler_par.sv
// Directed bench for scrambler_par: a W=1 and a W=8 instance driven from one sequence,
// expected beats queued by a reference model at accept time and popped when the DUT emits them.
module tb_scrambler_par;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // W=1 instance
  logic       v1, f1, l1, md1, rd1, ready1, ov1, lk1;
  logic [6:0] st1, sd1;
  logic [0:0] d1, od1;
  // W=8 instance
  logic       v8, f8, l8, md8, rd8, ready8, ov8, lk8;
  logic [6:0] st8, sd8;
  logic [7:0] d8, od8;

  scrambler_par #(.W(1)) u_dut1 (
    .iClk(clk), .iRst_n(rst_n), .iMode(md1), .iState(st1), .iData(d1),
    .iFirst(f1), .iLast(l1), .iValid(v1), .oReady(ready1), .oData(od1),
    .oValid(ov1), .iReady(rd1), .oLocked(lk1), .oSeed(sd1)
  );

  scrambler_par #(.W(8)) u_dut8 (
    .iClk(clk), .iRst_n(rst_n), .iMode(md8), .iState(st8), .iData(d8),
    .iFirst(f8), .iLast(l8), .iValid(v8), .oReady(ready8), .oData(od8),
    .oValid(ov8), .iReady(rd8), .oLocked(lk8), .oSeed(sd8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q1[$];
  logic [7:0] q8[$];

  // reference model state per instance (index 0 -> W=1, 1 -> W=8); state 0 idle, 1 recover, 2 run
  int         m_state[2];
  logic [6:0] m_lfsr[2];
  int         m_cnt[2];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_state[j] = 0;
      m_lfsr[j]  = '0;
      m_cnt[j]   = 0;
    end
  endtask

  task automatic model_beat(input logic id, input int w, input logic [7:0] d, input logic f,
                            input logic l, input logic md, input logic [6:0] st,
                            output logic prod, output logic [7:0] o);
    logic       k;
    logic [7:0] dv;
    prod = 1'b0;
    o    = '0;
    if (f) begin
      m_cnt[id] = 0;
      if (!md) begin
        m_lfsr[id]  = st;
        m_state[id] = 2;
      end else begin
        m_lfsr[id]  = '0;
        m_state[id] = 1;
      end
    end
    if (m_state[id] == 0) return;
    for (int i = 0; i < w; i++) begin
      dv = d >> i;
      if (m_state[id] == 1 && m_cnt[id] < 7) begin
        m_lfsr[id] = {m_lfsr[id][5:0], dv[0]};
        m_cnt[id]++;
        if (m_cnt[id] == 7) m_state[id] = 2;
      end else begin
        k = m_lfsr[id][6] ^ m_lfsr[id][3];
        o = o | (8'(dv[0] ^ k) << i);
        m_lfsr[id] = {m_lfsr[id][5:0], k};
      end
    end
    if (l) m_state[id] = 0;
    prod = 1'b1;
  endtask

  task automatic drive(input logic id, input logic v, input logic [7:0] d, input logic f,
                       input logic l, input logic md, input logic [6:0] st);
    if (!id) begin
      v1 = v; d1 = d[0]; f1 = f; l1 = l; md1 = md; st1 = st;
    end else begin
      v8 = v; d8 = d; f8 = f; l8 = l; md8 = md; st8 = st;
    end
  endtask

  // Present one beat until accepted; ovr >= 0 replaces the model value with a literal expectation.
  task automatic send(input logic id, input logic [7:0] d, input logic f, input logic l,
                      input logic md, input logic [6:0] st, input int ovr);
    logic       acc;
    logic       prod;
    logic [7:0] o;
    int         n;
    drive(id, 1'b1, d, f, l, md, st);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = id ? ready8 : ready1;
      @(posedge clk);
      #1;
      n++;
    end
    drive(id, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00);
    n_checks++;
    assert (acc === 1'b1) else begin
      n_fail++;
      $error("FAIL accept_timeout inst=%0d got=%b exp=1", id, acc);
    end
    if (acc) begin
      model_beat(id, id ? 8 : 1, d, f, l, md, st, prod, o);
      if (prod) begin
        if (ovr >= 0) o = 8'(ovr);
        if (id) q8.push_back(o);
        else    q1.push_back(o);
      end
    end
  endtask

  // Scoreboard: a beat leaves the DUT when oValid && iReady at the following rising edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && ov1 && rd1) begin
      n_checks++;
      assert (q1.size() != 0) else begin
        n_fail++;
        $error("FAIL out1_unexpected got=%h exp=none", od1);
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        n_checks++;
        assert (od1 === e[0:0]) else begin
          n_fail++;
          $error("FAIL out1_data got=%b exp=%b", od1, e[0]);
        end
      end
    end
    if (rst_n && ov8 && rd8) begin
      n_checks++;
      assert (q8.size() != 0) else begin
        n_fail++;
        $error("FAIL out8_unexpected got=%h exp=none", od8);
      end
      if (q8.size() != 0) begin
        e = q8.pop_front();
        n_checks++;
        assert (od8 === e) else begin
          n_fail++;
          $error("FAIL out8_data got=%h exp=%h", od8, e);
        end
      end
    end
  end

  initial begin
    logic [15:0] t1;
    logic [7:0]  r;
    t1 = 16'b0000_1110_1111_0010;
    rst_n = 1'b0;
    rd1 = 1'b1;
    rd8 = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid8", 8'(ov8), 8'h00);
    chk("rst_data8", od8, 8'h00);
    chk("rst_locked8", 8'(lk8), 8'h00);
    chk("rst_seed8", 8'(sd8), 8'h00);
    chk("rst_valid1", 8'(ov1), 8'h00);
    chk("rst_ready8", 8'(ready8), 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // W=1 TX, all-ones seed, zero data: literal keystream
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 8'h00, i == 0, i == 15, 1'b0, 7'h7F, int'(t1[15-i]));
      if (i == 0) begin
        chk("t1_locked", 8'(lk1), 8'h01);
        chk("t1_seed", 8'(sd1), 8'h7F);
      end
    end

    // W=1 RX fed with the TX stream: zeros out, lock after the seventh bit
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 8'(t1[15-i]), i == 0, i == 15, 1'b1, 7'h00, 0);
      if (i == 5) chk("t3_locked_early", 8'(lk1), 8'h00);
      if (i == 6) begin
        chk("t3_locked", 8'(lk1), 8'h01);
        chk("t3_seed", 8'(sd1), 8'h07);
      end
    end

    // RX frame ending before the seed is complete, then an orphan beat
    send(1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 7'h00, 0);
    send(1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 7'h00, 0);
    chk("short_rx_locked", 8'(lk1), 8'h00);
    send(1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 7'h00, -1);
    chk("short_rx_discard", 8'(ov1), 8'h00);

    // W=8 TX long frame, zero data
    for (int i = 0; i < 40; i++)
      send(1'b1, 8'h00, i == 0, i == 39, 1'b0, 7'h7F, i == 0 ? 'h70 : (i == 1 ? 'h4F : -1));
    chk("t2_locked", 8'(lk8), 8'h01);
    chk("t2_seed", 8'(sd8), 8'h7F);

    // all-zero seed: data passes straight through
    send(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 7'h00, 'hA5);
    chk("zero_seed_locked", 8'(lk8), 8'h01);

    // downstream stall mid-frame
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 8'h00, i == 0, i == 9, 1'b0, 7'h7F, i == 0 ? 'h70 : (i == 1 ? 'h4F : -1));
      if (i == 4) begin
        rd8 = 1'b0;
        drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00);
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", 8'(ov8), 8'h01);
          chk("stall_data", od8, q8[0]);
          chk("stall_ready", 8'(ready8), 8'h00);
        end
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00);
        rd8 = 1'b1;
      end
    end

    // reset mid-frame with a beat in flight
    for (int i = 0; i < 3; i++)
      send(1'b1, 8'(8'h11 * i), i == 0, 1'b0, 1'b0, 7'h7F, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 8'(ov8), 8'h00);
    chk("midrst_locked", 8'(lk8), 8'h00);
    chk("midrst_seed", 8'(sd8), 8'h00);
    q1.delete();
    q8.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 7'h00, -1);
    chk("postrst_drop0", 8'(ov8), 8'h00);
    send(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 7'h00, -1);
    chk("postrst_drop1", 8'(ov8), 8'h00);
    send(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 7'h7F, 'h70);
    send(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 7'h7F, 'h4F);
    chk("postrst_locked", 8'(lk8), 8'h01);

    // restart mid-frame, then a single-beat frame interrupting a running one
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom);
      send(1'b1, r, i == 0, 1'b0, 1'b0, 7'h7F, -1);
    end
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      send(1'b1, r, i == 0, 1'b0, 1'b0, 7'b1011101, -1);
      if (i == 0) chk("restart_seed", 8'(sd8), 8'h5D);
    end
    send(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'b1011101, -1);
    chk("single_seed", 8'(sd8), 8'h5D);
    send(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 7'h00, -1);
    chk("single_then_idle", 8'(ov8), 8'h00);
    chk("single_locked_hold", 8'(lk8), 8'h01);

    repeat (4) @(posedge clk);
    #1;
    chk("drain_q1", 8'(q1.size()), 8'h00);
    chk("drain_q8", 8'(q8.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
